// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller.
//   - Opcode constants for the two memory instructions and the nop IR.
//   - Two-bit FSM state encoding shared by the controller and its bench.
//   - Small opcode decode helpers.
package mem_stage_ctrl_pkg;

  localparam logic [4:0]  OP_SW  = 5'b00111;
  localparam logic [4:0]  OP_LW  = 5'b01000;
  localparam logic [31:0] NOP_IR = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic op_is_lw(input logic [4:0] opcode);
    return opcode == OP_LW;
  endfunction

  function automatic logic op_is_sw(input logic [4:0] opcode);
    return opcode == OP_SW;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_timer.sv
// mem_req_timer: counts cycles spent waiting for dmem_ack.
//   clock   in  rising-edge clock
//   reset   in  synchronous, active-high; clears the counter
//   run     in  1 while the controller sits in WAIT; 0 clears the counter
//   expired out 1 on the WAIT cycle where the counter reaches TIMEOUT-1
module mem_req_timer
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run) cnt_d = cnt_q + 1'b1;
  end

  // First WAIT cycle sees count 0, so expiry lands on the TIMEOUT-th WAIT cycle.
  assign expired = run && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: consumer side of the X/M latch.
// Issues a registered req/ack transaction to data memory for lw/sw, stalls
// the upstream stages while it is open, and feeds the M/W latch either the
// X/M contents or a bubble.
//   clock, reset             rising-edge clock, synchronous active-high reset
//   xm_o_in/b_in/ir_in/ovfl  X/M latch contents (result/address, store data, IR, overflow)
//   dmem_req/we/addr/wdata   registered request to data memory
//   dmem_rdata, dmem_ack     load data and one-cycle completion pulse
//   stall                    hold PC, F/D, D/X and X/M
//   mw_o/d/ir/ovfl_out       values for the M/W latch
//   mem_err                  one-cycle pulse after a timeout abort
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       xm_o_in,
  input  logic [31:0]       xm_b_in,
  input  logic [31:0]       xm_ir_in,
  input  logic              xm_ovfl_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic [31:0]       mw_o_out,
  output logic [31:0]       mw_d_out,
  output logic [31:0]       mw_ir_out,
  output logic              mw_ovfl_out,
  output logic              mem_err
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              timed_out;

  logic [4:0] opcode;
  logic       is_lw, is_sw;

  assign opcode = xm_ir_in[31:27];
  assign is_lw  = op_is_lw(opcode);
  assign is_sw  = op_is_sw(opcode);

  mem_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .run     (state_q == WAIT),
    .expired (timed_out)
  );

  // Next-state and request register updates.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_lw || is_sw) begin
          req_d   = 1'b1;
          we_d    = is_sw;
          addr_d  = xm_o_in[ADDR_W-1:0];
          wdata_d = xm_b_in;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Ack is checked first so an ack on the timeout cycle still completes.
        if (dmem_ack) begin
          req_d = 1'b0;
          if (!we_q) rdata_d = dmem_rdata;
          state_d = DONE;
        end else if (timed_out) begin
          req_d   = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // M/W latch feed: pass-through, bubble, or completed memory result.
  always_comb begin
    stall       = 1'b0;
    mw_o_out    = '0;
    mw_d_out    = '0;
    mw_ir_out   = NOP_IR;
    mw_ovfl_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_lw || is_sw) begin
          stall = 1'b1;
        end else begin
          mw_o_out    = xm_o_in;
          mw_ir_out   = xm_ir_in;
          mw_ovfl_out = xm_ovfl_in;
        end
      end
      WAIT: stall = 1'b1;
      DONE: begin
        // X/M still holds the memory instruction; it advances at this edge.
        mw_o_out    = xm_o_in;
        mw_ir_out   = xm_ir_in;
        mw_ovfl_out = xm_ovfl_in;
        mw_d_out    = is_lw ? rdata_q : 32'h0;
      end
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign mem_err    = err_q;

endmodule
